// File: rtl/playseq_fluxo_dados_n_pkg.sv
// Shared definitions for the PlaySeq datapath and control unit.
package playseq_fluxo_dados_n_pkg;

    // Memory selector encodings, also used by the control unit
    typedef enum logic [1:0] {
        SEL_MEM1    = 2'd0,
        SEL_MEM2    = 2'd1,
        SEL_MEM3    = 2'd2,
        SEL_GRAVADA = 2'd3
    } seletor_t;

    localparam int unsigned BOTOES_PADRAO      = 4;
    localparam int unsigned ADDR_PADRAO        = 4;
    localparam int unsigned SEQ_INICIAL_PADRAO = 5;
    localparam int unsigned M_JOGADA_PADRAO    = 5000;
    localparam int unsigned M_LED_PADRAO       = 500;

endpackage

// File: rtl/contador_m.sv
// Modulo-M period counter with a one-cycle end-of-period pulse.
module contador_m #(
    parameter int unsigned M = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int unsigned   W      = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0]  ULTIMO = W'(M - 1);

    logic [W-1:0] q;

    // Count while enabled, wrapping at M-1; clear has priority
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            q <= '0;
        end else if (conta) begin
            if (q == ULTIMO) q <= '0;
            else             q <= q + W'(1);
        end
    end

    assign fim = conta && !zera && !reset && (q == ULTIMO);

endmodule

// File: rtl/memoria_gravavel.sv
// User-recordable sequence RAM plus the recorded-length register.
module memoria_gravavel #(
    parameter int unsigned BOTOES = 4,
    parameter int unsigned ADDR   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              escreve,
    input  logic              zera,
    input  logic [ADDR-1:0]   endereco,
    input  logic [BOTOES-1:0] dado_escrita,
    output logic [BOTOES-1:0] dado_leitura,
    output logic [ADDR:0]     comprimento
);

    logic [BOTOES-1:0] mem [2**ADDR];
    logic [ADDR:0]     proximo;

    assign proximo      = {1'b0, endereco} + (ADDR + 1)'(1);
    assign dado_leitura = mem[endereco];

    // RAM write; contents are deliberately not cleared by reset or zera
    always_ff @(posedge clock) begin
        if (escreve && !zera && !reset) mem[endereco] <= dado_escrita;
    end

    // Recorded length grows to cover the highest written address
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            comprimento <= '0;
        end else if (escreve && (proximo > comprimento)) begin
            comprimento <= proximo;
        end
    end

endmodule

// File: rtl/playseq_fluxo_dados_n.sv
// PlaySeq datapath: counters, play register, comparators, timeouts, LEDs.
module playseq_fluxo_dados_n
    import playseq_fluxo_dados_n_pkg::*;
#(
    parameter int unsigned BOTOES      = BOTOES_PADRAO,
    parameter int unsigned ADDR        = ADDR_PADRAO,
    parameter int unsigned SEQ_INICIAL = SEQ_INICIAL_PADRAO,
    parameter int unsigned M_JOGADA    = M_JOGADA_PADRAO,
    parameter int unsigned M_LED       = M_LED_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BOTOES-1:0] botoes,
    input  logic [BOTOES-1:0] rom_dado,
    input  logic [1:0]        seletor_memoria,
    input  logic              zeraE,
    input  logic              contaE,
    input  logic              zeraS,
    input  logic              contaS,
    input  logic              carregaS,
    input  logic              zeraR,
    input  logic              registraR,
    input  logic              zeraT,
    input  logic              contaT,
    input  logic              zeraTL,
    input  logic              contaTL,
    input  logic              escreveM,
    input  logic              zeraM,
    input  logic              fase_preview,
    input  logic              controla_leds,
    output logic [ADDR-1:0]   endereco,
    output logic              igual,
    output logic              enderecoIgualSequencia,
    output logic              sequenciaMenorQueEndereco,
    output logic              fimE,
    output logic              fimS,
    output logic              tem_jogada,
    output logic              jogada_valida,
    output logic              timeout,
    output logic              timeout_led,
    output logic [ADDR:0]     comprimento,
    output logic [BOTOES-1:0] leds,
    output logic [BOTOES-1:0] db_dado,
    output logic [BOTOES-1:0] db_jogada,
    output logic [ADDR-1:0]   db_sequencia
);

    localparam logic [ADDR-1:0] SEQ_CARGA = ADDR'(SEQ_INICIAL % (2**ADDR));

    seletor_t          seletor;
    logic [ADDR-1:0]   sequencia;
    logic [BOTOES-1:0] registro;
    logic [BOTOES-1:0] ram_dado;
    logic [BOTOES-1:0] s_dado;
    logic              botao_anterior;

    assign seletor = seletor_t'(seletor_memoria);

    // Address counter, wraps naturally at 2^ADDR
    always_ff @(posedge clock) begin
        if (reset || zeraE) endereco <= '0;
        else if (contaE)    endereco <= endereco + ADDR'(1);
    end

    // Sequence limit depends on the selected memory
    always_comb begin
        fimS = 1'b0;
        if (seletor == SEL_GRAVADA)
            fimS = (comprimento == '0) ||
                   (({1'b0, sequencia} + (ADDR + 1)'(1)) >= comprimento);
        else
            fimS = (sequencia == '1);
    end

    // Sequence counter, saturating at its limit
    always_ff @(posedge clock) begin
        if (reset || zeraS)        sequencia <= '0;
        else if (carregaS)         sequencia <= SEQ_CARGA;
        else if (contaS && !fimS)  sequencia <= sequencia + ADDR'(1);
    end

    // Play register
    always_ff @(posedge clock) begin
        if (reset || zeraR)  registro <= '0;
        else if (registraR)  registro <= botoes;
    end

    // Button press edge detector on the OR of all buttons
    always_ff @(posedge clock) begin
        if (reset) begin
            botao_anterior <= 1'b0;
            tem_jogada     <= 1'b0;
        end else begin
            botao_anterior <= |botoes;
            tem_jogada     <= (|botoes) && !botao_anterior;
        end
    end

    memoria_gravavel #(
        .BOTOES (BOTOES),
        .ADDR   (ADDR)
    ) u_memoria (
        .clock        (clock),
        .reset        (reset),
        .escreve      (escreveM),
        .zera         (zeraM),
        .endereco     (endereco),
        .dado_escrita (registro),
        .dado_leitura (ram_dado),
        .comprimento  (comprimento)
    );

    contador_m #(.M(M_JOGADA)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (zeraT),
        .conta (contaT),
        .fim   (timeout)
    );

    contador_m #(.M(M_LED)) u_timeout_led (
        .clock (clock),
        .reset (reset),
        .zera  (zeraTL),
        .conta (contaTL),
        .fim   (timeout_led)
    );

    assign s_dado                    = (seletor == SEL_GRAVADA) ? ram_dado : rom_dado;
    assign igual                     = (s_dado == registro);
    assign jogada_valida             = (registro != '0) &&
                                       ((registro & (registro - BOTOES'(1))) == '0);
    assign fimE                      = (endereco == '1);
    assign enderecoIgualSequencia    = (sequencia == endereco);
    assign sequenciaMenorQueEndereco = (sequencia < endereco);

    // LED source: live buttons outside preview, stored data during preview
    always_comb begin
        leds = botoes;
        if (fase_preview) leds = controla_leds ? s_dado : '0;
    end

    assign db_dado      = s_dado;
    assign db_jogada    = registro;
    assign db_sequencia = sequencia;

endmodule

// File: tb/tb_playseq_fluxo_dados_n.sv
// Self-checking bench for the PlaySeq datapath.
module tb_playseq_fluxo_dados_n;

    localparam int unsigned BOTOES   = 4;
    localparam int unsigned ADDR     = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned SEQ_INI  = 5;
    localparam int unsigned M_JOGADA = 8;
    localparam int unsigned M_LED    = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic [BOTOES-1:0] botoes, rom_dado;
    logic [1:0]        seletor_memoria;
    logic zeraE, contaE, zeraS, contaS, carregaS, zeraR, registraR;
    logic zeraT, contaT, zeraTL, contaTL, escreveM, zeraM;
    logic fase_preview, controla_leds;
    logic [ADDR-1:0]   endereco, db_sequencia;
    logic              igual, enderecoIgualSequencia, sequenciaMenorQueEndereco;
    logic              fimE, fimS, tem_jogada, jogada_valida, timeout, timeout_led;
    logic [ADDR:0]     comprimento;
    logic [BOTOES-1:0] leds, db_dado, db_jogada;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    playseq_fluxo_dados_n #(
        .BOTOES(BOTOES), .ADDR(ADDR), .SEQ_INICIAL(SEQ_INI),
        .M_JOGADA(M_JOGADA), .M_LED(M_LED)
    ) dut (
        .clock(clock), .reset(reset), .botoes(botoes), .rom_dado(rom_dado),
        .seletor_memoria(seletor_memoria),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
        .carregaS(carregaS), .zeraR(zeraR), .registraR(registraR),
        .zeraT(zeraT), .contaT(contaT), .zeraTL(zeraTL), .contaTL(contaTL),
        .escreveM(escreveM), .zeraM(zeraM),
        .fase_preview(fase_preview), .controla_leds(controla_leds),
        .endereco(endereco), .igual(igual),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .sequenciaMenorQueEndereco(sequenciaMenorQueEndereco),
        .fimE(fimE), .fimS(fimS), .tem_jogada(tem_jogada),
        .jogada_valida(jogada_valida), .timeout(timeout), .timeout_led(timeout_led),
        .comprimento(comprimento), .leds(leds), .db_dado(db_dado),
        .db_jogada(db_jogada), .db_sequencia(db_sequencia)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        zeraE = 0; contaE = 0; zeraS = 0; contaS = 0; carregaS = 0;
        zeraR = 0; registraR = 0; zeraT = 0; contaT = 0; zeraTL = 0; contaTL = 0;
        escreveM = 0; zeraM = 0;
    endtask

    task automatic test_reset();
        idle();
        botoes = '0; rom_dado = '0; seletor_memoria = 2'd0;
        fase_preview = 0; controla_leds = 0;
        reset = 1; tick(); tick(); reset = 0; #1;
        tests++;
        if ({endereco, db_sequencia, db_jogada, comprimento} !== '0) begin
            fails++;
            $display("FAIL reset_state: end=%0d seq=%0d reg=%b comp=%0d, required all 0",
                     endereco, db_sequencia, db_jogada, comprimento);
        end
        tests++;
        if ({tem_jogada, timeout, timeout_led, fimS, fimE} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: tem=%b to=%b tl=%b fimS=%b fimE=%b, required 0",
                     tem_jogada, timeout, timeout_led, fimS, fimE);
        end
    endtask

    task automatic test_sequence();
        int unsigned exp;
        seletor_memoria = 2'd0;
        carregaS = 1; tick(); carregaS = 0; #1;
        tests++;
        if (db_sequencia !== 4'd5) begin
            fails++;
            $display("FAIL seq_load: got %0d, required 5", db_sequencia);
        end
        for (int i = 1; i <= 20; i++) begin
            contaS = 1; tick();
            exp = (SEQ_INI + i > DEPTH - 1) ? DEPTH - 1 : SEQ_INI + i;
            tests++;
            if (db_sequencia !== ADDR'(exp) || fimS !== (exp == DEPTH - 1)) begin
                fails++;
                $display("FAIL seq_count step %0d: seq=%0d fimS=%b, required seq=%0d fimS=%b",
                         i, db_sequencia, fimS, exp, exp == DEPTH - 1);
            end
        end
        idle();
    endtask

    task automatic test_record();
        logic [3:0] pat [3];
        pat = '{4'b0001, 4'b0100, 4'b1000};
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            botoes = pat[i]; registraR = 1; tick(); registraR = 0;
            escreveM = 1; contaE = 1; tick(); idle();
        end
        botoes = '0; #1;
        tests++;
        if (comprimento !== 5'd3 || endereco !== 4'd3) begin
            fails++;
            $display("FAIL record_len: comp=%0d end=%0d, required comp=3 end=3", comprimento, endereco);
        end
        seletor_memoria = 2'd3; zeraE = 1; zeraS = 1; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (db_dado !== pat[i] || fimS !== (i == 2)) begin
                fails++;
                $display("FAIL replay[%0d]: dado=%b fimS=%b, required dado=%b fimS=%b",
                         i, db_dado, fimS, pat[i], i == 2);
            end
            contaE = 1; contaS = 1; tick(); idle();
        end
        tests++;
        if (db_sequencia !== 4'd2) begin
            fails++;
            $display("FAIL replay_saturate: seq=%0d, required 2", db_sequencia);
        end
    endtask

    task automatic test_edge();
        logic [3:0] val, prev;
        int pulses = 0;
        botoes = '0; tick(); tick(); prev = '0;
        for (int c = 0; c < 21; c++) begin
            val = ((c < 10) || (c >= 13 && c < 18)) ? 4'b0010 : 4'b0000;
            botoes = val; tick();
            if (tem_jogada === 1'b1) pulses++;
            tests++;
            if (tem_jogada !== ((val != 0) && (prev == 0))) begin
                fails++;
                $display("FAIL edge cycle %0d: tem=%b, required %b", c, tem_jogada,
                         (val != 0) && (prev == 0));
            end
            if (c == 5) begin
                tests++;
                if (leds !== val) begin
                    fails++;
                    $display("FAIL leds_live: got %b, required %b", leds, val);
                end
            end
            prev = val;
        end
        tests++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL edge_pulses: got %0d, required 2", pulses);
        end
    endtask

    task automatic test_play();
        seletor_memoria = 2'd0;
        botoes = 4'b0110; registraR = 1; tick(); idle(); #1;
        tests++;
        if (jogada_valida !== 1'b0 || db_jogada !== 4'b0110) begin
            fails++;
            $display("FAIL play_multi: valida=%b reg=%b, required 0 / 0110", jogada_valida, db_jogada);
        end
        botoes = 4'b0100; registraR = 1; tick(); idle();
        rom_dado = 4'b0100; #1;
        tests++;
        if (igual !== 1'b1 || jogada_valida !== 1'b1) begin
            fails++;
            $display("FAIL play_match: igual=%b valida=%b, required 1 / 1", igual, jogada_valida);
        end
        rom_dado = 4'b0010; #1;
        tests++;
        if (igual !== 1'b0) begin
            fails++;
            $display("FAIL play_diff: igual=%b, required 0", igual);
        end
        fase_preview = 1; controla_leds = 1; #1;
        tests++;
        if (leds !== 4'b0010) begin
            fails++;
            $display("FAIL leds_preview_on: got %b, required 0010", leds);
        end
        controla_leds = 0; #1;
        tests++;
        if (leds !== 4'b0000) begin
            fails++;
            $display("FAIL leds_preview_off: got %b, required 0000", leds);
        end
        fase_preview = 0; botoes = 4'b1001; #1;
        tests++;
        if (leds !== 4'b1001) begin
            fails++;
            $display("FAIL leds_botoes: got %b, required 1001", leds);
        end
        botoes = '0; tick();
    endtask

    task automatic test_timeout();
        zeraT = 1; tick(); zeraT = 0; contaT = 1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            tests++;
            if (timeout !== (k % M_JOGADA == 0)) begin
                fails++;
                $display("FAIL timeout cycle %0d: got %b, required %b", k, timeout, k % M_JOGADA == 0);
            end
            tick();
        end
        zeraT = 1; tick();
        for (int k = 1; k <= 16; k++) begin
            zeraT = (k == 5); #1;
            tests++;
            if (timeout !== (k == 13)) begin
                fails++;
                $display("FAIL timeout_clear cycle %0d: got %b, required %b", k, timeout, k == 13);
            end
            tick();
        end
        idle();
        zeraTL = 1; tick(); zeraTL = 0; contaTL = 1;
        for (int k = 1; k <= 12; k++) begin
            #1;
            tests++;
            if (timeout_led !== (k % M_LED == 0)) begin
                fails++;
                $display("FAIL timeout_led cycle %0d: got %b, required %b", k, timeout_led, k % M_LED == 0);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midgame();
        seletor_memoria = 2'd3;
        zeraE = 1; tick(); idle(); contaE = 1; tick(); idle();
        botoes = 4'b1111; registraR = 1; tick(); idle();
        escreveM = 1; zeraM = 1; tick(); idle(); #1;
        tests++;
        if (comprimento !== '0 || db_dado !== 4'b0100 || fimS !== 1'b1) begin
            fails++;
            $display("FAIL write_and_clear: comp=%0d dado=%b fimS=%b, required 0 / 0100 / 1",
                     comprimento, db_dado, fimS);
        end
        botoes = '0; contaE = 1; contaS = 1; contaT = 1; contaTL = 1;
        tick(); tick(); tick();
        botoes = 4'b0001; reset = 1; tick(); #1;
        tests++;
        if ({endereco, db_sequencia, db_jogada, comprimento, tem_jogada, timeout, timeout_led} !== '0) begin
            fails++;
            $display("FAIL reset_midgame: end=%0d seq=%0d reg=%b comp=%0d tem=%b to=%b tl=%b, required 0",
                     endereco, db_sequencia, db_jogada, comprimento, tem_jogada, timeout, timeout_led);
        end
        tests++;
        if (db_dado !== 4'b0001) begin
            fails++;
            $display("FAIL ram_survives: dado=%b, required 0001", db_dado);
        end
        reset = 0; idle(); botoes = '0; tick();
    endtask

    task automatic test_random();
        int unsigned m_end, m_seq, m_comp, m_t, m_tl;
        logic [3:0]  m_reg, m_ram [DEPTH];
        bit          m_ok [DEPTH];
        bit          m_prev, m_tem, lim, known;
        logic [3:0]  e_dado, e_leds;
        for (int a = 0; a < DEPTH; a++) begin m_ok[a] = 0; m_ram[a] = '0; end
        idle(); reset = 1; tick(); reset = 0;
        m_end = 0; m_seq = 0; m_comp = 0; m_t = 0; m_tl = 0; m_reg = '0; m_prev = 0; m_tem = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) botoes = 4'($urandom_range(0, 15));
            rom_dado = 4'($urandom_range(0, 15));
            seletor_memoria = 2'($urandom_range(0, 3));
            zeraE = ($urandom_range(0, 15) == 0); contaE = 1'($urandom_range(0, 1));
            zeraS = ($urandom_range(0, 15) == 0); carregaS = ($urandom_range(0, 15) == 0);
            contaS = 1'($urandom_range(0, 1));
            zeraR = ($urandom_range(0, 15) == 0); registraR = ($urandom_range(0, 2) == 0);
            escreveM = ($urandom_range(0, 2) == 0); zeraM = ($urandom_range(0, 31) == 0);
            zeraT = ($urandom_range(0, 31) == 0); contaT = ($urandom_range(0, 7) != 0);
            zeraTL = ($urandom_range(0, 31) == 0); contaTL = 1'($urandom_range(0, 1));
            fase_preview = 1'($urandom_range(0, 1)); controla_leds = 1'($urandom_range(0, 1));
            #1;
            if (seletor_memoria == 3) lim = (m_comp == 0) || (m_seq + 1 >= m_comp);
            else                      lim = (m_seq == DEPTH - 1);
            known  = (seletor_memoria != 3) || m_ok[m_end];
            e_dado = (seletor_memoria == 3) ? m_ram[m_end] : rom_dado;
            e_leds = !fase_preview ? botoes : (controla_leds ? e_dado : 4'b0);
            tests++;
            if (endereco !== ADDR'(m_end) || db_sequencia !== ADDR'(m_seq) || db_jogada !== m_reg ||
                comprimento !== 5'(m_comp) || tem_jogada !== m_tem) begin
                fails++;
                $display("FAIL rand_state c%0d: end=%0d seq=%0d reg=%b comp=%0d tem=%b, required %0d %0d %b %0d %b",
                         c, endereco, db_sequencia, db_jogada, comprimento, tem_jogada,
                         m_end, m_seq, m_reg, m_comp, m_tem);
            end
            tests++;
            if (fimS !== lim || fimE !== (m_end == DEPTH - 1) || jogada_valida !== ($countones(m_reg) == 1) ||
                enderecoIgualSequencia !== (m_seq == m_end) || sequenciaMenorQueEndereco !== (m_seq < m_end) ||
                timeout !== (contaT && !zeraT && m_t == M_JOGADA - 1) ||
                timeout_led !== (contaTL && !zeraTL && m_tl == M_LED - 1)) begin
                fails++;
                $display("FAIL rand_flags c%0d: fimS=%b fimE=%b val=%b eq=%b lt=%b to=%b tl=%b, required %b %b %b %b %b %b %b",
                         c, fimS, fimE, jogada_valida, enderecoIgualSequencia, sequenciaMenorQueEndereco,
                         timeout, timeout_led, lim, m_end == DEPTH - 1, $countones(m_reg) == 1,
                         m_seq == m_end, m_seq < m_end, contaT && !zeraT && m_t == M_JOGADA - 1,
                         contaTL && !zeraTL && m_tl == M_LED - 1);
            end
            if (known) begin
                tests++;
                if (db_dado !== e_dado || igual !== (e_dado == m_reg) || leds !== e_leds) begin
                    fails++;
                    $display("FAIL rand_data c%0d: dado=%b igual=%b leds=%b, required %b %b %b",
                             c, db_dado, igual, leds, e_dado, e_dado == m_reg, e_leds);
                end
            end
            // reference update from the behavioural rules
            if (escreveM && !zeraM) begin m_ram[m_end] = m_reg; m_ok[m_end] = 1; end
            if (zeraM) m_comp = 0;
            else if (escreveM && m_end + 1 > m_comp) m_comp = m_end + 1;
            if (zeraS) m_seq = 0;
            else if (carregaS) m_seq = SEQ_INI % DEPTH;
            else if (contaS && !lim) m_seq = m_seq + 1;
            if (zeraE) m_end = 0;
            else if (contaE) m_end = (m_end + 1) % DEPTH;
            if (zeraR) m_reg = '0;
            else if (registraR) m_reg = botoes;
            m_tem  = (botoes != 0) && !m_prev;
            m_prev = (botoes != 0);
            if (zeraT) m_t = 0;
            else if (contaT) m_t = (m_t + 1) % M_JOGADA;
            if (zeraTL) m_tl = 0;
            else if (contaTL) m_tl = (m_tl + 1) % M_LED;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_record();
        test_edge();
        test_play();
        test_timeout();
        test_reset_midgame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/playseq_fluxo_dados_n.md
# playseq_fluxo_dados_n

Parametrised datapath for the PlaySeq game: button-width, sequence depth and timeout lengths are generics, and a fourth, user-recordable sequence memory is added alongside the three fixed ROMs. It holds the address and sequence-length counters, the play register and comparators, the timeout counters, the button edge detector and the LED multiplexing. It sits under the PlaySeq top level, driven by the PlaySeq control unit; the fixed ROMs stay outside and feed `rom_dado`.

## Interface
- `BOTOES`, 4, number of buttons/LEDs (data width)
- `ADDR`, 4, address width; sequence depth = 2^ADDR
- `SEQ_INICIAL`, 5, value loaded into the sequence counter by `carregaS`
- `M_JOGADA`, 5000, play-timeout period in cycles
- `M_LED`, 500, LED-display period in cycles

- `clock` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high; clears all state except RAM contents
- `botoes` in BOTOES: raw button levels, already synchronised
- `rom_dado` in BOTOES: data of the selected fixed ROM at `endereco`
- `seletor_memoria` in 2: 0–2 = `rom_dado`, 3 = recorded memory
- `zeraE`, `contaE`, `zeraS`, `contaS`, `carregaS`, `zeraR`, `registraR`, `zeraT`, `contaT`, `zeraTL`, `contaTL` in 1 each: counter/register controls
- `escreveM` in 1: write register contents into recorded memory at `endereco`
- `zeraM` in 1: clear recorded length
- `fase_preview`, `controla_leds` in 1: LED source selection
- `endereco` out ADDR: address counter value, drives external ROMs
- `igual`, `enderecoIgualSequencia`, `sequenciaMenorQueEndereco` out 1: comparator results
- `fimE`, `fimS` out 1: address at maximum; sequence at limit
- `tem_jogada` out 1: one-cycle pulse on a new press
- `jogada_valida` out 1: registered play is one-hot
- `timeout`, `timeout_led` out 1: period-end pulses
- `comprimento` out ADDR+1: recorded sequence length
- `leds` out BOTOES: LED drive
- `db_dado`, `db_jogada`, `db_sequencia` out BOTOES/BOTOES/ADDR: debug copies

## Operation
- Reset values: `endereco`, `sequencia`, register, timeout counters, `comprimento` and the edge-detector history all 0. Therefore `tem_jogada`, `timeout` and `timeout_led` are 0. `fimS` follows from the reset state.
- Control priority in every counter: `reset` > zera > carrega > conta.
- Address counter: `contaE` increments, wrapping from 2^ADDR-1 to 0. `fimE` = (`endereco` == 2^ADDR-1), combinational.
- Sequence counter: `carregaS` loads SEQ_INICIAL mod 2^ADDR; `contaS` increments, saturating at the limit.
  - Limit = 2^ADDR-1 for selectors 0–2.
  - Limit = `comprimento`-1 for selector 3; `fimS`=1 whenever `comprimento`==0.
- `s_dado` = `rom_dado` when selector < 3, else RAM[`endereco`]; RAM read is combinational.
- Play register: `registraR` captures `botoes`; `zeraR` clears it.
  - `jogada_valida` = exactly one bit set in the register.
  - `igual` = (`s_dado` == register), combinational.
- Comparators on (`sequencia`, `endereco`):
  - `enderecoIgualSequencia` = equality.
  - `sequenciaMenorQueEndereco` = `sequencia` < `endereco`, unsigned.
- Recording:
  - `escreveM` writes the register into RAM[`endereco`] on the edge.
  - `comprimento` becomes max(`comprimento`, `endereco`+1), max value 2^ADDR.
  - `zeraM` sets `comprimento` to 0; RAM contents are kept.
  - `escreveM` and `zeraM` together: `zeraM` wins and no write occurs.
- Edge detector: `tem_jogada`=1 for exactly one cycle after OR(`botoes`) goes 0→1. A held button gives one pulse; a release followed by a new press gives another.
- Timeout counters: count while enabled; `zeraT`/`zeraTL` clear them.
  - At count M-1 with the enable active, the counter wraps to 0 and the pulse is high for that cycle.
- LEDs:
  - `fase_preview`=0: `leds` = `botoes`.
  - `fase_preview`=1: `leds` = `s_dado` when `controla_leds`=1, else 0.

## Timing
- Counter, register and RAM updates are visible the cycle after the controlling strobe.
- `igual`, `fimE`, `fimS`, comparators, `jogada_valida` and `leds` are combinational from state and inputs, with zero latency.
- `tem_jogada` is asserted 1 cycle after the rising level on `botoes` is sampled.
- `timeout` is asserted in the M_JOGADA-th consecutive enabled cycle after a clear.
- `reset` in mid-game returns every counter to 0 on the next edge; the recorded RAM data survives but is unreachable until rewritten, because `comprimento`=0.

## Structure
- Shared package/header: selector encodings (`SEL_MEM1..SEL_GRAVADA`) and the default parameter values; the control unit uses the same encodings.
- Reuse `contador_m` for both timeouts.
- New sub-module `memoria_gravavel`: 2^ADDR × BOTOES RAM with synchronous write and asynchronous read, plus the `comprimento` register.

## Test plan
- Reset, then `carregaS`, then `contaS`×20 with selector 0 (ADDR=4) → `sequencia` 5,6…15, stays at 15; `fimS`=1 from 15.
- Record 3 entries 0001, 0100, 1000 at addresses 0–2 → `comprimento`=3. Replay with selector 3 → `db_dado` matches each entry; `fimS`=1 when `sequencia`=2.
- Hold `botoes`=0010 for 10 cycles, release, press again → exactly two one-cycle `tem_jogada` pulses.
- Register 0110 → `jogada_valida`=0; register 0100 with `s_dado`=0100 → `igual`=1, `jogada_valida`=1.
- `contaT` held with M_JOGADA=8 → `timeout` pulses at cycles 8 and 16; `zeraT` at cycle 5 pushes the first pulse to cycle 13.
- `escreveM`+`zeraM` together, then `reset` mid-count → `comprimento`=0, all counters 0, `tem_jogada`=0.
